// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit.
// Issues one data-memory request per op and holds the pipeline until done.
module mem_stage_lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic             WDMEM,
    input  logic             isLoadM,
    input  logic [2:0]       MemTypeM,
    input  logic [4:0]       RdM,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_we,
    output logic [WIDTH-1:0] mem_req_addr,
    output logic [WIDTH-1:0] mem_req_wdata,
    output logic [3:0]       mem_req_be,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_rdata,
    output logic             StallMem,
    output logic [WIDTH-1:0] LoadDataM,
    output logic             LoadValidM,
    output logic [4:0]       LoadRdM,
    output logic             MisalignM,
    output logic             BusErrM
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t r_state, w_next;

    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_ldata;
    logic [2:0]       r_type;
    logic [4:0]       r_rd;
    logic             r_we;
    logic [3:0]       r_be;
    logic             r_err;
    logic [CW-1:0]    r_cnt;

    logic             w_op;
    logic             w_we;
    logic             w_mis;
    logic             w_cap;
    logic             w_timeout;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_ext;

    // A simultaneous load and store resolves to the load.
    assign w_op      = isLoadM | WDMEM;
    assign w_we      = WDMEM & ~isLoadM;
    assign w_off     = ALUResultM[1:0];
    assign w_cap     = (r_state == IDLE) && w_op && !w_mis;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_mis   = 1'b0;
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        unique case (MemTypeM[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_mis   = w_off[0];
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: w_mis = |w_off;
        endcase
    end

    assign w_shift = mem_rsp_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = w_shift;
        unique case (r_type)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {24'd0, w_shift[7:0]};
            3'b101:  w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        StallMem      = 1'b0;
        MisalignM     = 1'b0;
        mem_req_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_op) begin
                    if (w_mis) begin
                        MisalignM = 1'b1;
                    end else begin
                        StallMem = 1'b1;
                        w_next   = REQ;
                    end
                end
            end
            REQ: begin
                StallMem      = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = r_we ? DONE : WAIT;
            end
            WAIT: begin
                StallMem = 1'b1;
                if (mem_rsp_valid || w_timeout) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ldata <= '0;
            r_type  <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cap) begin
                r_addr  <= ALUResultM;
                r_wdata <= w_wdata;
                r_type  <= MemTypeM;
                r_rd    <= RdM;
                r_we    <= w_we;
                r_be    <= w_be;
                r_err   <= 1'b0;
            end
            if (r_state == REQ) r_cnt <= '0;
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + CW'(1);
                if (mem_rsp_valid) begin
                    r_ldata <= w_ext;
                end else if (w_timeout) begin
                    r_ldata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign mem_req_we    = r_we;
    assign mem_req_addr  = {r_addr[WIDTH-1:2], 2'b00};
    assign mem_req_wdata = r_wdata;
    assign mem_req_be    = r_be;
    assign LoadDataM     = r_ldata;
    assign LoadRdM       = r_rd;
    assign LoadValidM    = (r_state == DONE) && !r_we;
    assign BusErrM       = (r_state == DONE) && r_err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed ops checked against a byte-lane model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
    localparam int TO = 255;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        WDMEM;
    logic        isLoadM;
    logic [2:0]  MemTypeM;
    logic [4:0]  RdM;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        StallMem;
    logic [31:0] LoadDataM;
    logic        LoadValidM;
    logic [4:0]  LoadRdM;
    logic        MisalignM;
    logic        BusErrM;

    mem_stage_lsu #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .WDMEM(WDMEM), .isLoadM(isLoadM),
        .MemTypeM(MemTypeM), .RdM(RdM),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .StallMem(StallMem), .LoadDataM(LoadDataM),
        .LoadValidM(LoadValidM), .LoadRdM(LoadRdM),
        .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        if (t == 3'b000 || t == 3'b100) return 1;
        if (t == 3'b001 || t == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input logic [2:0] t, input logic [31:0] a);
        return (a % nbytes(t)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        logic [3:0] r;
        int o = int'(a % 4);
        int n = nbytes(t);
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = (i >= o) && (i < o + n);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
        logic [31:0] r;
        int n = nbytes(t);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v = 0;
        int o = int'(a % 4);
        int n = nbytes(t);
        for (int k = 0; k < n; k++) v += longint'(rd[8*(o+k) +: 8]) << (8*k);
        if ((t == 3'b000 || t == 3'b001) && v >= (longint'(1) << (8*n - 1)))
            v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    logic [31:0] e_addr, e_wd, e_ld, e_hold;
    logic [3:0]  e_be;
    logic        e_we;
    logic [4:0]  e_rd;
    bit          mon_en = 0;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (mem_req_valid) begin
                check("req_addr", mem_req_addr, e_addr);
                check("req_be", {28'd0, mem_req_be}, {28'd0, e_be});
                check("req_we", {31'd0, mem_req_we}, {31'd0, e_we});
                if (e_we) check("req_wdata", mem_req_wdata, e_wd);
            end
            if (LoadValidM) begin
                check("load_data", LoadDataM, e_ld);
                check("load_rd", {27'd0, LoadRdM}, {27'd0, e_rd});
                e_hold = e_ld;
            end else begin
                check("load_hold", LoadDataM, e_hold);
            end
        end
    end

    logic [31:0] l_addr, l_wd;
    logic [3:0]  l_be;
    logic        l_we;

    task automatic op(input string nm, input bit ld, input bit st, input logic [2:0] t,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input int rdy_dly, input int rsp_dly, input bit no_rsp,
                      input bit junk, input bit nop_after, input logic [31:0] rdata,
                      input int exp_stall);
        int stl = 0, hs = 0, lv = 0, be = 0, mis = 0, vld = 0, reqc = 0, rc = -1;
        bit fin = 0;
        bit is_mis;
        bit is_ld;
        is_mis = (ld || st) && m_mis(t, a);
        is_ld  = ld && !is_mis;
        e_addr = a & 32'hFFFF_FFFC;
        e_be   = m_be(t, a);
        e_we   = st && !ld;
        e_wd   = m_wdata(t, wd);
        e_ld   = no_rsp ? 32'd0 : m_load(t, a, rdata);
        e_rd   = rd;
        isLoadM = ld; WDMEM = st; MemTypeM = t;
        ALUResultM = a; WriteDataM = wd; RdM = rd;
        mem_req_ready = 0; mem_rsp_valid = 0;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            stl += int'(StallMem);
            lv  += int'(LoadValidM);
            be  += int'(BusErrM);
            mis += int'(MisalignM);
            vld += int'(mem_req_valid);
            if (is_mis) fin = (c == 3);
            else if (!StallMem && c > 0) fin = 1;
            if (nop_after && c == 1) begin
                isLoadM = 0; WDMEM = 0; RdM = 0;
                ALUResultM = $urandom; WriteDataM = $urandom;
                MemTypeM = 3'($urandom_range(0, 7));
            end
            mem_rsp_valid = 0;
            mem_rsp_rdata = $urandom;
            if (mem_req_valid) begin
                mem_req_ready = (reqc >= rdy_dly);
                if (junk && !mem_req_ready) mem_rsp_valid = 1;
                reqc++;
                if (mem_req_ready) begin
                    hs++; rc = 0;
                    l_addr = mem_req_addr; l_wd = mem_req_wdata;
                    l_be = mem_req_be; l_we = mem_req_we;
                end
            end else begin
                mem_req_ready = 0;
                if (rc >= 0) begin
                    if (!no_rsp && rc == rsp_dly) begin
                        mem_rsp_valid = 1;
                        mem_rsp_rdata = rdata;
                    end
                    rc++;
                end
            end
        end
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL %s done: op never completed within cycle budget", nm);
        end
        @(posedge clk); #1;
        isLoadM = 0; WDMEM = 0; mem_req_ready = 0; mem_rsp_valid = 0;
        check({nm, " stall"}, stl, exp_stall);
        check({nm, " hs"}, hs, is_mis ? 0 : 1);
        check({nm, " reqcyc"}, vld, is_mis ? 0 : rdy_dly + 1);
        check({nm, " lvalid"}, lv, is_ld ? 1 : 0);
        check({nm, " buserr"}, be, (is_ld && no_rsp) ? 1 : 0);
        check({nm, " misalign"}, mis, is_mis ? 4 : 0);
    endtask

    initial begin
        rst_n = 0; isLoadM = 0; WDMEM = 0; MemTypeM = 0; RdM = 0;
        ALUResultM = 0; WriteDataM = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
        e_hold = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst stall", {31'd0, StallMem}, 0);
        check("rst valid", {31'd0, mem_req_valid}, 0);
        check("rst ldata", LoadDataM, 0);
        check("rst lvalid", {31'd0, LoadValidM}, 0);
        check("rst buserr", {31'd0, BusErrM}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        mon_en = 1;

        op("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 2);
        check("sw addr", l_addr, 32'h100);
        check("sw be", {28'd0, l_be}, 32'hF);
        check("sw wdata", l_wd, 32'hDEADBEEF);
        check("sw we", {31'd0, l_we}, 1);
        op("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 1, 0, 0, 0, 2);
        check("sb addr", l_addr, 32'h100);
        check("sb be", {28'd0, l_be}, 32'h8);
        check("sb wdata", l_wd, 32'hA5A5A5A5);
        op("sh", 0, 1, 3'b001, 32'h102, 32'h1234CAFE, 0, 0, 0, 1, 0, 0, 0, 2);
        check("sh be", {28'd0, l_be}, 32'hC);
        check("sh wdata", l_wd, 32'hCAFECAFE);
        op("lb", 1, 0, 3'b000, 32'h202, 0, 7, 0, 0, 0, 0, 0, 32'h12F03456, 3);
        check("lb data", LoadDataM, 32'hFFFFFFF0);
        check("lb rd", {27'd0, LoadRdM}, 7);
        op("lbu", 1, 0, 3'b100, 32'h202, 0, 8, 0, 0, 0, 0, 0, 32'h12F03456, 3);
        check("lbu data", LoadDataM, 32'h000000F0);
        op("lh", 1, 0, 3'b001, 32'h202, 0, 9, 0, 0, 0, 0, 0, 32'h80011234, 3);
        check("lh data", LoadDataM, 32'hFFFF8001);
        op("lhu", 1, 0, 3'b101, 32'h202, 0, 10, 0, 0, 0, 0, 0, 32'h80011234, 3);
        check("lhu data", LoadDataM, 32'h00008001);
        op("lb3", 1, 0, 3'b000, 32'h003, 0, 11, 0, 0, 0, 0, 0, 32'h7F000000, 3);
        check("lb3 data", LoadDataM, 32'h0000007F);
        op("lw_rdy", 1, 0, 3'b010, 32'h300, 0, 12, 4, 0, 0, 1, 1, 32'hCAFEBABE, 7);
        check("lw_rdy addr", l_addr, 32'h300);
        check("lw_rdy data", LoadDataM, 32'hCAFEBABE);
        op("lw_rsp", 1, 0, 3'b010, 32'h304, 0, 13, 0, 3, 0, 0, 0, 32'h01020304, 6);
        op("ld_st", 1, 1, 3'b010, 32'h010, 32'h55555555, 14, 0, 0, 0, 0, 0, 32'h11223344, 3);
        check("ld_st we", {31'd0, l_we}, 0);
        check("ld_st data", LoadDataM, 32'h11223344);
        op("sw011", 0, 1, 3'b011, 32'h020, 32'h89ABCDEF, 0, 0, 0, 1, 0, 0, 0, 2);
        check("sw011 be", {28'd0, l_be}, 32'hF);
        op("lw111", 1, 0, 3'b111, 32'h024, 0, 15, 0, 0, 0, 0, 0, 32'hF00DF00D, 3);
        check("lw111 data", LoadDataM, 32'hF00DF00D);
        op("lh_mis", 1, 0, 3'b001, 32'h301, 0, 16, 0, 0, 0, 0, 0, 0, 0);
        op("sw_mis", 0, 1, 3'b010, 32'h102, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0);
        op("lw_to", 1, 0, 3'b010, 32'h400, 0, 5, 0, 0, 1, 0, 0, 0, 2 + TO);
        check("lw_to data", LoadDataM, 0);
        op("lw_pre", 1, 0, 3'b010, 32'h500, 0, 6, 0, 0, 0, 0, 0, 32'h0BADCAFE, 3);

        mon_en = 0;
        isLoadM = 1; MemTypeM = 3'b010; ALUResultM = 32'h600; RdM = 3;
        @(negedge clk);
        @(negedge clk);
        check("rq valid", {31'd0, mem_req_valid}, 1);
        #2 rst_n = 0; isLoadM = 0;
        #1 check("rq rst valid", {31'd0, mem_req_valid}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("rq rel stall", {31'd0, StallMem}, 0);
        check("rq rel ldata", LoadDataM, 0);

        isLoadM = 1;
        @(negedge clk);
        @(negedge clk); mem_req_ready = 1;
        @(negedge clk); mem_req_ready = 0;
        check("wt stall", {31'd0, StallMem}, 1);
        #2 rst_n = 0; isLoadM = 0;
        #1 check("wt rst valid", {31'd0, mem_req_valid}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("wt rel stall", {31'd0, StallMem}, 0);
        check("wt rel valid", {31'd0, mem_req_valid}, 0);
        check("wt rel lvalid", {31'd0, LoadValidM}, 0);
        @(posedge clk); #1;
        e_hold = 0;
        mon_en = 1;
        op("sw_post", 0, 1, 3'b010, 32'h700, 32'h13579BDF, 0, 0, 0, 1, 0, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
